// File: rtl/cache_line_refill_ctrl.sv
// cache_line_refill_ctrl
//
// Miss handler that sits directly behind the RAM cache. On a read miss it
// fetches the four-word line holding the missed address from backing
// memory, one word per request/response pair. It then presents
// {tag, set, line} to the cache as a one-cycle fill. The CPU pipeline is
// stalled from the accept cycle through the fill cycle.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   miss_valid     cache reports a read miss (sampled only when idle)
//   miss_addr      missed byte address
//   miss_ready     controller idle and able to accept a miss
//   mem_req_valid  word read request to backing memory
//   mem_req_addr   word-aligned request address
//   mem_req_ready  memory accepts the request
//   mem_resp_valid read data returned (sampled only while waiting)
//   mem_resp_data  returned word
//   fill_valid     one-cycle pulse: write the fill line into the cache
//   fill_set       set index of the filled line
//   fill_tag       tag of the filled line
//   fill_line      {word3, word2, word1, word0}, word0 in the low bits
//   stall          freeze the CPU pipeline
module cache_line_refill_ctrl #(
  parameter int ADDRESS_WIDTH       = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int LINE_WORDS          = 4,
  parameter int CACHE_ADDRESS_WIDTH = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         miss_valid,
  input  logic [ADDRESS_WIDTH-1:0]                     miss_addr,
  output logic                                         miss_ready,
  output logic                                         mem_req_valid,
  output logic [ADDRESS_WIDTH-1:0]                     mem_req_addr,
  input  logic                                         mem_req_ready,
  input  logic                                         mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                        mem_resp_data,
  output logic                                         fill_valid,
  output logic [CACHE_ADDRESS_WIDTH-1:0]               fill_set,
  output logic [ADDRESS_WIDTH-CACHE_ADDRESS_WIDTH-5:0] fill_tag,
  output logic [LINE_WORDS*DATA_WIDTH-1:0]             fill_line,
  output logic                                         stall
);

  localparam int CNT_W   = $clog2(LINE_WORDS);
  localparam int OFS_W   = CNT_W + 2;                      // block + byte offset
  localparam int LADDR_W = ADDRESS_WIDTH - OFS_W;          // line address width
  localparam int TAG_W   = LADDR_W - CACHE_ADDRESS_WIDTH;
  localparam int LINE_W  = LINE_WORDS * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [LADDR_W-1:0]        line_addr_q;
  logic [DATA_WIDTH-1:0]     word_q [LINE_WORDS];
  logic [CACHE_ADDRESS_WIDTH-1:0] fill_set_q;
  logic [TAG_W-1:0]          fill_tag_q;
  logic [LINE_W-1:0]         fill_line_q;
  logic [LINE_W-1:0]         line_next;
  logic                      accept;
  logic                      resp_take;
  logic                      last_word;

  // The line is always fetched from word 0 upward, so the low address bits of
  // the miss carry no information for the refill.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[OFS_W-1:0];

  function automatic logic [ADDRESS_WIDTH-1:0] word_addr(
    input logic [LADDR_W-1:0] line_addr,
    input logic [CNT_W-1:0]   idx
  );
    return {line_addr, idx, 2'b00};
  endfunction

  assign accept    = (state_q == IDLE) && miss_valid;
  assign resp_take = (state_q == WAIT) && mem_resp_valid;
  assign last_word = (cnt_q == LAST_WORD);

  // Line image as it will look once the word now returning is stored; lets
  // the fill register capture the complete line on the final response.
  always_comb begin
    line_next = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (CNT_W'(i) == cnt_q) begin
        line_next[i*DATA_WIDTH +: DATA_WIDTH] = mem_resp_data;
      end else begin
        line_next[i*DATA_WIDTH +: DATA_WIDTH] = word_q[i];
      end
    end
  end

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next state and control outputs ----
  always_comb begin
    state_d       = state_q;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    fill_valid    = 1'b0;
    stall         = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        // Freeze the pipeline in the accept cycle itself; held off while
        // reset is asserted so the reset value of stall is 0.
        stall      = miss_valid & ~rst;
        if (miss_valid) begin
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        stall         = 1'b1;
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          state_d = last_word ? FILL : REQ;
        end
      end
      FILL: begin
        fill_valid = 1'b1;
        stall      = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- refill datapath: latched address, word counter, line buffer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      line_addr_q <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        line_addr_q <= miss_addr[ADDRESS_WIDTH-1:OFS_W];
        cnt_q       <= '0;
      end
      if (resp_take) begin
        word_q[cnt_q] <= mem_resp_data;
        if (!last_word) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // ---- fill registers: loaded on the last response, held until next fill ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_set_q  <= '0;
      fill_tag_q  <= '0;
      fill_line_q <= '0;
    end else if (resp_take && last_word) begin
      fill_set_q  <= line_addr_q[CACHE_ADDRESS_WIDTH-1:0];
      fill_tag_q  <= line_addr_q[LADDR_W-1:CACHE_ADDRESS_WIDTH];
      fill_line_q <= line_next;
    end
  end

  // The request address is derived from registered state only, so it holds
  // steady for as long as the memory keeps ready low.
  assign mem_req_addr = word_addr(line_addr_q, cnt_q);
  assign fill_set     = fill_set_q;
  assign fill_tag     = fill_tag_q;
  assign fill_line    = fill_line_q;

endmodule

// File: tb/tb_cache_line_refill_ctrl.sv
// Testbench for cache_line_refill_ctrl: a backing-memory model answers each
// accepted request one cycle later with data = address ^ 0xA5A5_0000, and
// a scoreboard holds the expected request addresses and fill lines.
module tb_cache_line_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_data;
  logic         fill_valid;
  logic [3:0]   fill_set;
  logic [23:0]  fill_tag;
  logic [127:0] fill_line;
  logic         stall;

  cache_line_refill_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .miss_valid     (miss_valid),
    .miss_addr      (miss_addr),
    .miss_ready     (miss_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .fill_valid     (fill_valid),
    .fill_set       (fill_set),
    .fill_tag       (fill_tag),
    .fill_line      (fill_line),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   set;
    logic [23:0]  tag;
    logic [127:0] line;
    int           t0;
    int           cyc;
  } fill_t;

  fill_t       fillq [$];
  logic [31:0] reqq  [$];

  int vectors     = 0;
  int miscompares = 0;
  int fill_cnt    = 0;
  int stall_cnt   = 0;

  // memory model knobs, set by the stimulus process
  logic [31:0] bp_addr   = 32'h0;
  int          bp_left   = 0;
  int          spur_left = 0;
  bit          late_resp = 1'b0;
  bit          pend      = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] exp_line(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  wa;
    l = '0;
    for (int i = 0; i < 4; i++) begin
      wa = {a[31:4], 4'h0} + 32'(i * 4);
      l[i*32 +: 32] = wa ^ 32'hA5A5_0000;
    end
    return l;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic push_miss(input logic [31:0] a, input int t0, input int lat);
    fill_t e;
    for (int i = 0; i < 4; i++) reqq.push_back({a[31:4], 4'h0} + 32'(i * 4));
    e.set  = a[7:4];
    e.tag  = a[31:8];
    e.line = exp_line(a);
    e.t0   = t0;
    e.cyc  = t0 + lat;
    fillq.push_back(e);
  endtask

  // drive a one-cycle miss in the current cycle; returns one cycle later
  task automatic do_miss(input logic [31:0] a, input int bp);
    bp_addr = {a[31:4], 4'h4};
    bp_left = bp;
    push_miss(a, cyc, 9 + bp);
    miss_valid = 1'b1;
    miss_addr  = a;
    next_cycle();
    miss_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (fillq.size() != 0 && n < limit) begin
      next_cycle();
      n++;
    end
    chk("done_timeout", 128'(fillq.size()), 128'd0);
  endtask

  // monitor + backing memory, evaluated mid-cycle
  initial begin
    fill_t e;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      chk("stall", 128'(stall), miss_ready ? 128'(miss_valid & ~rst) : 128'd1);
      if (rst) stall_cnt = 0;
      else if (stall) stall_cnt++;

      if (fill_valid) begin
        fill_cnt++;
        if (fillq.size() == 0) begin
          chk("unexpected_fill", 128'd1, 128'd0);
        end else begin
          e = fillq.pop_front();
          chk("fill_set",    128'(fill_set),  128'(e.set));
          chk("fill_tag",    128'(fill_tag),  128'(e.tag));
          chk("fill_line",   fill_line,       e.line);
          chk("fill_cycle",  128'(cyc),       128'(e.cyc));
          chk("stall_cycles", 128'(stall_cnt), 128'(e.cyc - e.t0 + 1));
        end
        stall_cnt = 0;
      end

      if (mem_req_valid) begin
        if (reqq.size() == 0) chk("unexpected_req", 128'd1, 128'd0);
        else chk("req_addr", 128'(mem_req_addr), 128'(reqq[0]));
      end

      // response for this cycle
      if (pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = pend_addr ^ 32'hA5A5_0000;
        pend = 1'b0;
      end else if (late_resp) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        late_resp = 1'b0;
      end else if (mem_req_valid && spur_left > 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        spur_left--;
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
      end

      // ready for this cycle, and the handshake it produces
      if (mem_req_valid && bp_left > 0 && mem_req_addr == bp_addr) begin
        mem_req_ready = 1'b0;
        bp_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (mem_req_valid && mem_req_ready && !rst) begin
        pend      = 1'b1;
        pend_addr = mem_req_addr;
        if (reqq.size() != 0) void'(reqq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst        = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = 32'h0;
    #1 rst = 1'b1;
    repeat (2) next_cycle();
    chk("rst_miss_ready", 128'(miss_ready),    128'd1);
    chk("rst_req_valid",  128'(mem_req_valid), 128'd0);
    chk("rst_fill_valid", 128'(fill_valid),    128'd0);
    chk("rst_req_addr",   128'(mem_req_addr),  128'd0);
    chk("rst_fill_line",  fill_line,           128'd0);
    rst = 1'b0;
    next_cycle();

    // zero-wait refill
    t0 = cyc;
    do_miss(32'h0001_0024, 0);
    wait_done(40);
    chk("t1_idle_cycle", 128'(cyc),        128'(t0 + 10));
    chk("t1_miss_ready", 128'(miss_ready), 128'd1);
    next_cycle();

    // backpressure on word 1
    do_miss(32'h0001_0024, 3);
    wait_done(40);
    next_cycle();

    // spurious miss and spurious response mid-refill
    spur_left = 1;
    do_miss(32'h0001_0024, 0);
    next_cycle();
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0200;
    next_cycle();
    miss_valid = 1'b0;
    wait_done(40);
    repeat (3) next_cycle();
    chk("t3_fill_count", 128'(fill_cnt), 128'd3);

    // reset while waiting on word 2
    do_miss(32'h0001_0024, 0);
    repeat (5) next_cycle();
    chk("t4_in_wait", 128'({mem_req_valid, stall}), 128'b01);
    rst = 1'b1;
    #1;
    chk("t4_req_valid",  128'(mem_req_valid), 128'd0);
    chk("t4_stall",      128'(stall),         128'd0);
    chk("t4_miss_ready", 128'(miss_ready),    128'd1);
    chk("t4_fill_valid", 128'(fill_valid),    128'd0);
    chk("t4_fill_tag",   128'(fill_tag),      128'd0);
    chk("t4_fill_line",  fill_line,           128'd0);
    reqq.delete();
    fillq.delete();
    next_cycle();
    next_cycle();
    rst       = 1'b0;
    late_resp = 1'b1;
    next_cycle();
    do_miss(32'h0000_0040, 0);
    wait_done(40);
    chk("t4_fill_count", 128'(fill_cnt), 128'd4);
    next_cycle();

    // back-to-back misses with miss_valid held high
    t0 = cyc;
    push_miss(32'h0000_0100, t0, 9);
    push_miss(32'h0000_0200, t0 + 10, 9);
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0100;
    next_cycle();
    miss_addr  = 32'h0000_0200;
    repeat (10) next_cycle();
    miss_valid = 1'b0;
    wait_done(40);

    // fill outputs hold after the last fill
    repeat (3) next_cycle();
    chk("hold_fill_tag",   128'(fill_tag),   128'h2);
    chk("hold_fill_set",   128'(fill_set),   128'h0);
    chk("hold_fill_line",  fill_line,        exp_line(32'h0000_0200));
    chk("total_fills",     128'(fill_cnt),   128'd6);
    chk("req_queue_empty", 128'(reqq.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_line_refill_ctrl.md
Name: cache_line_refill_ctrl

Overview:
- Miss handler directly downstream of the spatial-locality RAM-cache: on a cache read miss it fetches the 4-word line containing the missed address from backing memory, one word at a time, over a valid/ready request and valid response interface.
- Assembles {valid, tag, 4 words} and presents it as a one-cycle fill to the cache.
- Asserts stall to the CPU pipeline for the whole refill, converting the cache's single-cycle combinational RAM fallback into a realistic multi-cycle memory access.

Parameters:
- ADDRESS_WIDTH, 32, byte address width; tag = A[31:8], set = A[7:4], block offset = A[3:2], byte offset = A[1:0].
- DATA_WIDTH, 32, memory word width.
- LINE_WORDS, 4, words per cache line; fixed at 4, and other values are unsupported.
- CACHE_ADDRESS_WIDTH, 4, set index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- miss_valid  input  1  cache reports a read miss this cycle.
- miss_addr  input  ADDRESS_WIDTH  missed byte address.
- miss_ready  output  1  controller idle and able to accept a miss.
- mem_req_valid  output  1  word read request to backing memory.
- mem_req_addr  output  ADDRESS_WIDTH  word-aligned request address.
- mem_req_ready  input  1  memory accepts the request.
- mem_resp_valid  input  1  read data returned.
- mem_resp_data  input  DATA_WIDTH  returned word.
- fill_valid  output  1  one-cycle pulse: write the fill line into the cache.
- fill_set  output  CACHE_ADDRESS_WIDTH  set index, miss_addr[7:4].
- fill_tag  output  24  tag, miss_addr[31:8].
- fill_line  output  4*DATA_WIDTH  {word3, word2, word1, word0}; word0 occupies bits [31:0].
- stall  output  1  freeze the CPU pipeline.

Behaviour:
- Reset (async, rst=1): state=IDLE, word counter=0, latched address=0, line buffer=0. Output values during reset:
  - mem_req_valid=0, fill_valid=0, stall=0, miss_ready=1.
  - fill_set, fill_tag, fill_line and mem_req_addr all 0.
- Reset mid-refill: the partial line is discarded and no fill is issued. An in-flight memory response arriving after reset deasserts is ignored.
- FSM states: IDLE, REQ, WAIT, FILL.
  - IDLE: miss_ready=1. If miss_valid=1, latch miss_addr, clear counter, go to REQ. stall = miss_valid (combinational), so the pipeline freezes in the accept cycle.
  - REQ: mem_req_valid=1 and mem_req_addr = {addr[31:4], cnt[1:0], 2'b00}. The address holds stable while ready=0. On mem_req_ready=1, go to WAIT.
  - WAIT: on mem_resp_valid=1, store mem_resp_data into line word[cnt]. If cnt==3, go to FILL; otherwise cnt++ and go to REQ.
  - FILL: fill_valid=1 for exactly one cycle, then go to IDLE.
- fill_set, fill_tag and fill_line are registered. They are valid in the FILL cycle and hold their values until the next fill.
- stall=1 in REQ, WAIT and FILL.
- miss_valid is ignored outside IDLE.
- mem_resp_valid is ignored outside WAIT; a response is never accepted in the same cycle as its request handshake.
- Words are fetched in order 0,1,2,3 regardless of miss_addr[3:2]; miss_addr[1:0] is ignored.
- Only one request is outstanding at a time.
- Latency with zero-wait memory (ready=1, response one cycle after the handshake):
  - Accept at cycle 0; REQ/WAIT pairs occupy cycles 1 to 8.
  - FILL at cycle 9; IDLE (miss_ready=1) at cycle 10.
  - Each extra ready-low or response-wait cycle adds one cycle.
- The counter is 2 bits and never wraps past 3 within a refill.

Test Plan:
- Zero-wait refill, miss_addr=0x0001_0024, memory word at byte address X = X ^ 0xA5A5_0000:
  - mem_req_addr sequence 0x10020, 0x10024, 0x10028, 0x1002C.
  - fill_valid at cycle 9 with fill_set=2 and fill_tag=0x000100.
  - fill_line = {0xA5A5002C^0x10000, ..., 0xA5A50020^0x10000}, i.e. each word per the rule.
  - stall high for cycles 0 to 9.
- Backpressure: mem_req_ready low for 3 cycles on word 1 -> mem_req_addr holds 0x10024 throughout, fill_valid at cycle 12, and fill_line is unchanged from the zero-wait case.
- Spurious inputs:
  - A second miss_valid with addr 0x200 mid-refill is ignored.
  - A mem_resp_valid pulse during REQ is ignored.
  - Only the line of 0x0001_0024 is filled, and exactly one fill_valid pulse occurs.
- Reset asserted asynchronously in WAIT of word 2 -> outputs return to reset values immediately, with no fill_valid. A new miss at 0x40 afterwards fills set 4, tag 0, with correct data.
- Back-to-back misses: miss_valid held high with addr 0x100, then 0x200 -> the second miss is accepted in the cycle after FILL. Two fills occur, at set 0 with tag 0x000001 and at set 0 with tag 0x000002.
